// File: rtl/eh2_dec_trigger_ctl_if.sv
// Decode-stage trigger sequencer bus: raw d-stage matches and trigger CSR state in,
// registered e1 matches, hit bits and halt handshake out.
interface eh2_dec_trigger_ctl_if #(
  parameter int NUM_THREADS = 2,
  parameter int NUM_TRIG    = 4
);
  logic [NUM_TRIG-1:0]             dec_i0_trigger_match_d;
  logic [NUM_TRIG-1:0]             dec_i1_trigger_match_d;
  logic                            dec_i0_valid_d;
  logic                            dec_i1_valid_d;
  logic                            dec_i0_tid_d;
  logic                            dec_i1_tid_d;
  logic [2*NUM_THREADS-1:0]        trig_chain;
  logic [NUM_TRIG*NUM_THREADS-1:0] trig_action;
  logic [NUM_TRIG*NUM_THREADS-1:0] trig_hit_clr;
  logic [NUM_THREADS-1:0]          dbg_halt_ack;
  logic [NUM_TRIG-1:0]             dec_i0_trigger_match_e1;
  logic [NUM_TRIG-1:0]             dec_i1_trigger_match_e1;
  logic                            dec_i0_bkpt_exc_e1;
  logic                            dec_i1_bkpt_exc_e1;
  logic [NUM_THREADS-1:0]          trig_halt_req;
  logic [NUM_TRIG*NUM_THREADS-1:0] trig_hit;
  logic                            trig_busy;

  modport master (
    output dec_i0_trigger_match_d, dec_i1_trigger_match_d, dec_i0_valid_d, dec_i1_valid_d,
    output dec_i0_tid_d, dec_i1_tid_d, trig_chain, trig_action, trig_hit_clr, dbg_halt_ack,
    input  dec_i0_trigger_match_e1, dec_i1_trigger_match_e1, dec_i0_bkpt_exc_e1,
    input  dec_i1_bkpt_exc_e1, trig_halt_req, trig_hit, trig_busy
  );

  modport slave (
    input  dec_i0_trigger_match_d, dec_i1_trigger_match_d, dec_i0_valid_d, dec_i1_valid_d,
    input  dec_i0_tid_d, dec_i1_tid_d, trig_chain, trig_action, trig_hit_clr, dbg_halt_ack,
    output dec_i0_trigger_match_e1, dec_i1_trigger_match_e1, dec_i0_bkpt_exc_e1,
    output dec_i1_bkpt_exc_e1, trig_halt_req, trig_hit, trig_busy
  );
endinterface

// File: rtl/eh2_dec_trigger_ctl.sv
// Per-thread trigger sequencer: chaining, lane priority, action select, sticky hits, halt handshake.
// Optional feature macro: TRIG_CHAIN_EN (pairwise trigger chaining {0,1},{2,3}).
module eh2_dec_trigger_ctl #(
  parameter int NUM_THREADS = 2,
  parameter int NUM_TRIG    = 4
) (
  input logic                clk,
  input logic                rst,
  eh2_dec_trigger_ctl_if.slave bus
);

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, DONE = 2'd2} state_t;

  state_t                          state_r [NUM_THREADS];
  logic [NUM_THREADS-1:0]          halt_req_r;
  logic [NUM_TRIG*NUM_THREADS-1:0] hit_r;
  logic [NUM_TRIG-1:0]             i0_match_e1_r, i1_match_e1_r;
  logic                            i0_bkpt_e1_r, i1_bkpt_e1_r;

  int                              i0_t_s, i1_t_s;
  logic [NUM_TRIG-1:0]             i0_gate_s, i1_gate_s, i0_fire_s, i1_chain_s, i1_fire_s;
  logic [NUM_TRIG-1:0]             i0_act_s, i1_act_s;
  logic                            i0_dbg_s, i1_dbg_s, i0_bkpt_s, i1_bkpt_s;
  logic                            i0_idle_s, i1_idle_s, busy_s;
  logic [NUM_TRIG*NUM_THREADS-1:0] hit_set_s, hit_next_s;
  logic [NUM_THREADS-1:0]          dbg_req_s;

  function automatic int tidx(input logic tid);
    return (NUM_THREADS > 1) ? int'(tid) : 0;
  endfunction

`ifdef TRIG_CHAIN_EN
  // A chained pair fires only as a whole, when both members match the same instruction.
  function automatic logic [NUM_TRIG-1:0] chain_apply(input logic [NUM_TRIG-1:0] m,
                                                      input logic [1:0] ch);
    logic [NUM_TRIG-1:0] f;
    f = m;
    if (ch[0]) f[1:0] = {2{&m[1:0]}};
    else       f[1:0] = m[1:0];
    if (ch[1]) f[3:2] = {2{&m[3:2]}};
    else       f[3:2] = m[3:2];
    return f;
  endfunction
`else
  logic unused_chain_s;
  assign unused_chain_s = ^bus.trig_chain;
`endif

  // Lane gating, chaining, i0-over-i1 priority and per-lane action decode.
  always_comb begin
    i0_t_s = tidx(bus.dec_i0_tid_d);
    i1_t_s = tidx(bus.dec_i1_tid_d);
    if (bus.dec_i0_valid_d) i0_gate_s = bus.dec_i0_trigger_match_d;
    else                    i0_gate_s = {NUM_TRIG{1'b0}};
    if (bus.dec_i1_valid_d) i1_gate_s = bus.dec_i1_trigger_match_d;
    else                    i1_gate_s = {NUM_TRIG{1'b0}};
`ifdef TRIG_CHAIN_EN
    i0_fire_s  = chain_apply(i0_gate_s, bus.trig_chain[2*i0_t_s +: 2]);
    i1_chain_s = chain_apply(i1_gate_s, bus.trig_chain[2*i1_t_s +: 2]);
`else
    i0_fire_s  = i0_gate_s;
    i1_chain_s = i1_gate_s;
`endif
    if ((|i0_fire_s) && (i0_t_s == i1_t_s)) i1_fire_s = {NUM_TRIG{1'b0}};
    else                                    i1_fire_s = i1_chain_s;
    i0_act_s  = bus.trig_action[NUM_TRIG*i0_t_s +: NUM_TRIG];
    i1_act_s  = bus.trig_action[NUM_TRIG*i1_t_s +: NUM_TRIG];
    i0_dbg_s  = |(i0_fire_s & i0_act_s);
    i1_dbg_s  = |(i1_fire_s & i1_act_s);
    i0_bkpt_s = (|(i0_fire_s & ~i0_act_s)) & ~i0_dbg_s;
    i1_bkpt_s = (|(i1_fire_s & ~i1_act_s)) & ~i1_dbg_s;
    i0_idle_s = (state_r[i0_t_s] == IDLE);
    i1_idle_s = (state_r[i1_t_s] == IDLE);
  end

  // Route lane fires to their owning thread; set beats clear on the hit bits.
  always_comb begin
    hit_set_s = {(NUM_TRIG*NUM_THREADS){1'b0}};
    dbg_req_s = {NUM_THREADS{1'b0}};
    busy_s    = 1'b0;
    for (int t = 0; t < NUM_THREADS; t++) begin
      if (i0_t_s == t) begin
        hit_set_s[NUM_TRIG*t +: NUM_TRIG] = hit_set_s[NUM_TRIG*t +: NUM_TRIG] | i0_fire_s;
        dbg_req_s[t] = dbg_req_s[t] | i0_dbg_s;
      end else begin
        hit_set_s[NUM_TRIG*t +: NUM_TRIG] = hit_set_s[NUM_TRIG*t +: NUM_TRIG];
      end
      if (i1_t_s == t) begin
        hit_set_s[NUM_TRIG*t +: NUM_TRIG] = hit_set_s[NUM_TRIG*t +: NUM_TRIG] | i1_fire_s;
        dbg_req_s[t] = dbg_req_s[t] | i1_dbg_s;
      end else begin
        dbg_req_s[t] = dbg_req_s[t];
      end
      busy_s = busy_s | (state_r[t] != IDLE);
    end
    hit_next_s = (hit_r & ~bus.trig_hit_clr) | hit_set_s;
  end

  // e1 pipeline registers; a thread that is halting or halted reports nothing new.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      i0_match_e1_r <= {NUM_TRIG{1'b0}};
      i1_match_e1_r <= {NUM_TRIG{1'b0}};
      i0_bkpt_e1_r  <= 1'b0;
      i1_bkpt_e1_r  <= 1'b0;
      hit_r         <= {(NUM_TRIG*NUM_THREADS){1'b0}};
    end else begin
      i0_match_e1_r <= i0_idle_s ? i0_fire_s : {NUM_TRIG{1'b0}};
      i1_match_e1_r <= i1_idle_s ? i1_fire_s : {NUM_TRIG{1'b0}};
      i0_bkpt_e1_r  <= i0_idle_s & i0_bkpt_s;
      i1_bkpt_e1_r  <= i1_idle_s & i1_bkpt_s;
      hit_r         <= hit_next_s;
    end
  end

  // Halt-request handshake FSM per thread; DONE waits for software to clear all hit bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int t = 0; t < NUM_THREADS; t++) state_r[t] <= IDLE;
      halt_req_r <= {NUM_THREADS{1'b0}};
    end else begin
      for (int t = 0; t < NUM_THREADS; t++) begin
        case (state_r[t])
          IDLE: begin
            if (dbg_req_s[t]) begin
              state_r[t]    <= REQ;
              halt_req_r[t] <= 1'b1;
            end else begin
              halt_req_r[t] <= 1'b0;
            end
          end
          REQ: begin
            if (bus.dbg_halt_ack[t]) begin
              state_r[t]    <= DONE;
              halt_req_r[t] <= 1'b0;
            end else begin
              halt_req_r[t] <= 1'b1;
            end
          end
          DONE: begin
            halt_req_r[t] <= 1'b0;
            if (hit_r[NUM_TRIG*t +: NUM_TRIG] == {NUM_TRIG{1'b0}}) state_r[t] <= IDLE;
            else                                                   state_r[t] <= DONE;
          end
          default: begin
            state_r[t]    <= IDLE;
            halt_req_r[t] <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.dec_i0_trigger_match_e1 = i0_match_e1_r;
  assign bus.dec_i1_trigger_match_e1 = i1_match_e1_r;
  assign bus.dec_i0_bkpt_exc_e1      = i0_bkpt_e1_r;
  assign bus.dec_i1_bkpt_exc_e1      = i1_bkpt_e1_r;
  assign bus.trig_halt_req           = halt_req_r;
  assign bus.trig_hit                = hit_r;
  assign bus.trig_busy               = busy_s;

endmodule

// File: tb/tb_eh2_dec_trigger_ctl.sv
// Directed self-checking bench for eh2_dec_trigger_ctl (NUM_THREADS=2).
module tb_eh2_dec_trigger_ctl;
  logic clk;
  logic rst;
  int   checks;
  int   failures;

  eh2_dec_trigger_ctl_if #(.NUM_THREADS(2), .NUM_TRIG(4)) bus ();
  eh2_dec_trigger_ctl #(.NUM_THREADS(2), .NUM_TRIG(4)) dut (.clk(clk), .rst(rst), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    bus.dec_i0_trigger_match_d = 4'b0000;
    bus.dec_i1_trigger_match_d = 4'b0000;
    bus.dec_i0_valid_d = 1'b0;
    bus.dec_i1_valid_d = 1'b0;
    bus.dec_i0_tid_d   = 1'b0;
    bus.dec_i1_tid_d   = 1'b0;
    bus.trig_hit_clr   = 8'h00;
    bus.dbg_halt_ack   = 2'b00;
  endtask

  task automatic clear_all_hits;
    idle_inputs();
    bus.trig_hit_clr = 8'hFF;
    tick();
    bus.trig_hit_clr = 8'h00;
    tick();
  endtask

  task automatic test_reset;
    rst = 1'b1;
    idle_inputs();
    bus.trig_chain  = 4'b0000;
    bus.trig_action = 8'h00;
    tick();
    tick();
    checks++;
    if (bus.trig_hit !== 8'h00 || bus.trig_halt_req !== 2'b00 || bus.trig_busy !== 1'b0 ||
        bus.dec_i0_trigger_match_e1 !== 4'b0000 || bus.dec_i1_trigger_match_e1 !== 4'b0000 ||
        bus.dec_i0_bkpt_exc_e1 !== 1'b0 || bus.dec_i1_bkpt_exc_e1 !== 1'b0) begin
      failures++;
      $display("FAIL reset_state hit=%h halt=%b busy=%b m0=%b m1=%b (all expected 0)",
               bus.trig_hit, bus.trig_halt_req, bus.trig_busy,
               bus.dec_i0_trigger_match_e1, bus.dec_i1_trigger_match_e1);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_bkpt;
    bus.dec_i0_valid_d = 1'b1;
    bus.dec_i0_trigger_match_d = 4'b0001;
    bus.dec_i1_trigger_match_d = 4'b0010;  // invalid lane must contribute nothing
    tick();
    idle_inputs();
    checks++;
    if (bus.dec_i0_trigger_match_e1 !== 4'b0001) begin
      failures++;
      $display("FAIL bkpt_match got=%b exp=0001", bus.dec_i0_trigger_match_e1);
    end
    checks++;
    if (bus.dec_i0_bkpt_exc_e1 !== 1'b1 || bus.trig_halt_req !== 2'b00) begin
      failures++;
      $display("FAIL bkpt_exc got=%b halt=%b exp=1 00", bus.dec_i0_bkpt_exc_e1, bus.trig_halt_req);
    end
    checks++;
    if (bus.trig_hit !== 8'h01 || bus.dec_i1_trigger_match_e1 !== 4'b0000) begin
      failures++;
      $display("FAIL bkpt_hit got=%h m1=%b exp=01 0000", bus.trig_hit, bus.dec_i1_trigger_match_e1);
    end
    clear_all_hits();
    checks++;
    if (bus.trig_hit !== 8'h00) begin
      failures++;
      $display("FAIL hit_clear got=%h exp=00", bus.trig_hit);
    end
  endtask

  task automatic test_chain;
    logic [3:0] exp_first;
`ifdef TRIG_CHAIN_EN
    exp_first = 4'b0000;
`else
    exp_first = 4'b0001;
`endif
    bus.trig_chain = 4'b0001;
    bus.dec_i0_valid_d = 1'b1;
    bus.dec_i0_trigger_match_d = 4'b0001;
    tick();
    bus.dec_i0_trigger_match_d = 4'b0011;
    checks++;
    if (bus.dec_i0_trigger_match_e1 !== exp_first) begin
      failures++;
      $display("FAIL chain_half got=%b exp=%b", bus.dec_i0_trigger_match_e1, exp_first);
    end
    tick();
    idle_inputs();
    checks++;
    if (bus.dec_i0_trigger_match_e1 !== 4'b0011) begin
      failures++;
      $display("FAIL chain_both got=%b exp=0011", bus.dec_i0_trigger_match_e1);
    end
    bus.trig_chain = 4'b0000;
    clear_all_hits();
  endtask

  task automatic test_priority;
    bus.dec_i0_valid_d = 1'b1;
    bus.dec_i1_valid_d = 1'b1;
    bus.dec_i0_trigger_match_d = 4'b0100;
    bus.dec_i1_trigger_match_d = 4'b1000;
    tick();
    bus.dec_i1_tid_d = 1'b1;
    checks++;
    if (bus.dec_i0_trigger_match_e1 !== 4'b0100 || bus.dec_i1_trigger_match_e1 !== 4'b0000 ||
        bus.dec_i1_bkpt_exc_e1 !== 1'b0) begin
      failures++;
      $display("FAIL prio_same_tid m0=%b m1=%b b1=%b exp=0100 0000 0", bus.dec_i0_trigger_match_e1,
               bus.dec_i1_trigger_match_e1, bus.dec_i1_bkpt_exc_e1);
    end
    tick();
    idle_inputs();
    checks++;
    if (bus.dec_i1_trigger_match_e1 !== 4'b1000 || bus.dec_i1_bkpt_exc_e1 !== 1'b1) begin
      failures++;
      $display("FAIL prio_diff_tid m1=%b b1=%b exp=1000 1", bus.dec_i1_trigger_match_e1,
               bus.dec_i1_bkpt_exc_e1);
    end
    checks++;
    if (bus.trig_hit !== 8'b1000_0100) begin
      failures++;
      $display("FAIL prio_hits got=%b exp=10000100", bus.trig_hit);
    end
    clear_all_hits();
  endtask

  task automatic test_debug_handshake;
    bus.trig_action = 8'h04;
    bus.dec_i0_valid_d = 1'b1;
    bus.dec_i0_trigger_match_d = 4'b0100;
    tick();
    idle_inputs();
    checks++;
    if (bus.trig_halt_req !== 2'b01 || bus.dec_i0_trigger_match_e1 !== 4'b0100 ||
        bus.dec_i0_bkpt_exc_e1 !== 1'b0 || bus.trig_busy !== 1'b1) begin
      failures++;
      $display("FAIL dbg_req halt=%b m0=%b b0=%b busy=%b exp=01 0100 0 1", bus.trig_halt_req,
               bus.dec_i0_trigger_match_e1, bus.dec_i0_bkpt_exc_e1, bus.trig_busy);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (bus.trig_halt_req !== 2'b01) begin
        failures++;
        $display("FAIL dbg_hold cycle=%0d got=%b exp=01", i, bus.trig_halt_req);
      end
    end
    bus.dbg_halt_ack = 2'b01;
    tick();
    bus.dbg_halt_ack = 2'b00;
    checks++;
    if (bus.trig_halt_req !== 2'b00 || bus.trig_busy !== 1'b1) begin
      failures++;
      $display("FAIL dbg_ack halt=%b busy=%b exp=00 1", bus.trig_halt_req, bus.trig_busy);
    end
  endtask

  task automatic test_done_suppress;
    bus.dec_i0_valid_d = 1'b1;
    bus.dec_i0_trigger_match_d = 4'b0001;
    tick();
    checks++;
    if (bus.dec_i0_trigger_match_e1 !== 4'b0000 || bus.dec_i0_bkpt_exc_e1 !== 1'b0 ||
        bus.trig_halt_req !== 2'b00 || bus.trig_hit !== 8'h05) begin
      failures++;
      $display("FAIL done_suppress m0=%b b0=%b halt=%b hit=%h exp=0000 0 00 05",
               bus.dec_i0_trigger_match_e1, bus.dec_i0_bkpt_exc_e1, bus.trig_halt_req, bus.trig_hit);
    end
    bus.trig_hit_clr = 8'h01;
    tick();
    idle_inputs();
    checks++;
    if (bus.trig_hit !== 8'h05) begin
      failures++;
      $display("FAIL set_wins_clr got=%h exp=05", bus.trig_hit);
    end
    bus.trig_hit_clr = 8'h05;
    tick();
    bus.trig_hit_clr = 8'h00;
    checks++;
    if (bus.trig_hit !== 8'h00 || bus.trig_busy !== 1'b1) begin
      failures++;
      $display("FAIL done_clr hit=%h busy=%b exp=00 1", bus.trig_hit, bus.trig_busy);
    end
    tick();
    checks++;
    if (bus.trig_busy !== 1'b0) begin
      failures++;
      $display("FAIL done_to_idle busy=%b exp=0", bus.trig_busy);
    end
  endtask

  task automatic test_back_to_back;
    bus.trig_action = 8'h44;
    bus.dec_i0_valid_d = 1'b1;
    bus.dec_i1_valid_d = 1'b1;
    bus.dec_i1_tid_d   = 1'b1;
    bus.dec_i0_trigger_match_d = 4'b0100;
    bus.dec_i1_trigger_match_d = 4'b0100;
    tick();
    idle_inputs();
    checks++;
    if (bus.trig_halt_req !== 2'b11 || bus.trig_hit !== 8'h44) begin
      failures++;
      $display("FAIL b2b_req halt=%b hit=%h exp=11 44", bus.trig_halt_req, bus.trig_hit);
    end
    bus.dbg_halt_ack = 2'b11;
    tick();
    idle_inputs();
    checks++;
    if (bus.trig_halt_req !== 2'b00) begin
      failures++;
      $display("FAIL b2b_ack halt=%b exp=00", bus.trig_halt_req);
    end
    clear_all_hits();
    checks++;
    if (bus.trig_busy !== 1'b0) begin
      failures++;
      $display("FAIL b2b_idle busy=%b exp=0", bus.trig_busy);
    end
  endtask

  task automatic test_reset_mid_req;
    bus.trig_action = 8'h04;
    bus.dec_i0_valid_d = 1'b1;
    bus.dec_i0_trigger_match_d = 4'b0100;
    tick();
    idle_inputs();
    checks++;
    if (bus.trig_halt_req !== 2'b01) begin
      failures++;
      $display("FAIL rst_pre halt=%b exp=01", bus.trig_halt_req);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (bus.trig_halt_req !== 2'b00 || bus.trig_hit !== 8'h00 || bus.trig_busy !== 1'b0) begin
      failures++;
      $display("FAIL rst_async halt=%b hit=%h busy=%b exp=00 00 0", bus.trig_halt_req,
               bus.trig_hit, bus.trig_busy);
    end
    tick();
    rst = 1'b0;
    tick();
    checks++;
    if (bus.trig_halt_req !== 2'b00 || bus.trig_busy !== 1'b0) begin
      failures++;
      $display("FAIL rst_release halt=%b busy=%b exp=00 0", bus.trig_halt_req, bus.trig_busy);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_bkpt();
    test_chain();
    test_priority();
    test_debug_handshake();
    test_done_suppress();
    test_back_to_back();
    test_reset_mid_req();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
